// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - bundle of CPU, VGA and RAM port signals around the video RAM arbiter
//
// Purpose: carries the CPU data port, the VGA scanout read port and the
// single-port RAM port as one bundle. The arbiter binds to the slave modport.
// The master modport is the mirror view used by whatever drives the requesters
// and models the RAM.
//
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack/cpu_stall        CPU completion and stall
//   vga_req/vga_addr                   scanout read request, held until vga_ack
//   vga_rdata/vga_ack                  scanout completion
//   ram_en/ram_we/ram_addr/ram_wdata   registered RAM port drive
//   ram_rdata                          RAM read data
interface vram_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_ack;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  vga_req, vga_addr,
        output vga_rdata, vga_ack,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output vga_req, vga_addr,
        input  vga_rdata, vga_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares the single-port text-mode video RAM between the CPU and VGA scanout
//
// Purpose: grants one RAM access at a time to either the CPU data port or the
// VGA scanout reader. Each access takes two cycles: the request is sampled in
// IDLE, the RAM port is driven during BUSY, and the owner's read data and
// one-cycle ack appear in the following cycle. VGA wins contested rounds
// unless the CPU has already lost MAX_WAIT rounds in a row.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    vram_arbiter_if.slave: CPU port, VGA port and RAM port
module vram_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 13,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    vram_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic {
        IDLE,
        BUSY
    } stateT;

    stateT             state;
    logic              ownerCpu;
    logic [3:0]        waitCnt;

    logic              ramEn;
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramWdata;
    logic              cpuAck;
    logic              vgaAck;
    logic [DATA_W-1:0] cpuRdata;
    logic [DATA_W-1:0] vgaRdata;

    logic              cpuWins;
    logic              vgaWins;

    // CPU takes the round when it is alone or when it has been starved long enough.
    always_comb begin
        cpuWins = 1'b0;
        vgaWins = 1'b0;
        if (bus.cpu_req && (!bus.vga_req || waitCnt == MAX_WAIT_C)) begin
            cpuWins = 1'b1;
        end else if (bus.vga_req) begin
            vgaWins = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ownerCpu <= 1'b0;
            waitCnt  <= 4'd0;
            ramEn    <= 1'b0;
            ramWe    <= 1'b0;
            ramAddr  <= '0;
            ramWdata <= '0;
            cpuAck   <= 1'b0;
            vgaAck   <= 1'b0;
            cpuRdata <= '0;
            vgaRdata <= '0;
        end else begin
            // A CPU that stops asking forfeits its accumulated priority.
            if (!bus.cpu_req) begin
                waitCnt <= 4'd0;
            end

            case (state)
                IDLE: begin
                    cpuAck <= 1'b0;
                    vgaAck <= 1'b0;
                    ramEn  <= 1'b0;
                    ramWe  <= 1'b0;
                    if (cpuWins) begin
                        ramEn    <= 1'b1;
                        ramWe    <= bus.cpu_we;
                        ramAddr  <= bus.cpu_addr;
                        ramWdata <= bus.cpu_wdata;
                        ownerCpu <= 1'b1;
                        waitCnt  <= 4'd0;
                        state    <= BUSY;
                    end else if (vgaWins) begin
                        // Scanout is read-only; ram_wdata keeps its last value.
                        ramEn    <= 1'b1;
                        ramWe    <= 1'b0;
                        ramAddr  <= bus.vga_addr;
                        ownerCpu <= 1'b0;
                        state    <= BUSY;
                        if (bus.cpu_req && waitCnt != MAX_WAIT_C) begin
                            waitCnt <= waitCnt + 4'd1;
                        end
                    end
                end

                BUSY: begin
                    // ramWe still reflects the granted access here, so it tells
                    // whether the CPU read data register should be updated.
                    ramEn <= 1'b0;
                    ramWe <= 1'b0;
                    if (ownerCpu) begin
                        cpuAck <= 1'b1;
                        if (!ramWe) begin
                            cpuRdata <= bus.ram_rdata;
                        end
                    end else begin
                        vgaAck   <= 1'b1;
                        vgaRdata <= bus.ram_rdata;
                    end
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_en    = ramEn;
    assign bus.ram_we    = ramWe;
    assign bus.ram_addr  = ramAddr;
    assign bus.ram_wdata = ramWdata;
    assign bus.cpu_ack   = cpuAck;
    assign bus.vga_ack   = vgaAck;
    assign bus.cpu_rdata = cpuRdata;
    assign bus.vga_rdata = vgaRdata;
    assign bus.cpu_stall = bus.cpu_req & ~cpuAck;
endmodule
